ibex_bus_arbiter: RTL and testbench

IBEX_BUS_ARBITER -- requirements
Module: ibex_bus_arbiter

---
 rtl/ibex_pkg.sv | 14 +
 rtl/ibex_arb_owner_fifo.sv | 67 ++++++
 rtl/ibex_bus_arbiter.sv | 133 +++++++++++++
 tb/tb_ibex_bus_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// Shared types for the instruction/data bus arbiter.
package ibex_pkg;

    typedef enum logic {
        ARB_INSTR = 1'b0,
        ARB_DATA  = 1'b1
    } arb_owner_e;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/ibex_arb_owner_fifo.sv
// In-order FIFO of bus owners for granted transactions still waiting on a response.
module ibex_arb_owner_fifo
    import ibex_pkg::*;
#(
    parameter int unsigned Depth = 2,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push,
    input  arb_owner_e      push_owner,
    input  logic            pop,
    output logic            full,
    output logic            empty,
    output arb_owner_e      head,
    output logic [CntW-1:0] count
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    arb_owner_e            mem_q [Depth];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  do_push, do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CntW'(Depth));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
        if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_owner;
    end

endmodule

// File: rtl/ibex_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and LSU,
// holding the selection while a request waits for grant and routing responses in order.
module ibex_bus_arbiter
    import ibex_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic        instr_err_o,
    output logic [31:0] instr_rdata_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic        data_err_o,
    output logic [31:0] data_rdata_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic        bus_err_i,
    input  logic [31:0] bus_rdata_i
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    arb_state_e      state_q, state_d;
    arb_owner_e      lock_owner_q, lock_owner_d;
    arb_owner_e      last_owner_q, last_owner_d;
    arb_owner_e      sel, head;
    logic            sel_req, handshake, pop;
    logic            fifo_full, fifo_empty;
    logic [CntW-1:0] fifo_count;
    // Set by reset until the first new handshake: stray responses in this window
    // belong to transactions discarded by the reset.
    logic            stale_ok_q;

    always_comb begin
        sel = ARB_INSTR;
        if (state_q == ARB_LOCKED) begin
            sel = lock_owner_q;
        end else if (instr_req_i && data_req_i) begin
            sel = (last_owner_q == ARB_INSTR) ? ARB_DATA : ARB_INSTR;
        end else if (data_req_i) begin
            sel = ARB_DATA;
        end
    end

    assign sel_req   = (sel == ARB_INSTR) ? instr_req_i : data_req_i;
    // Gated on the registered count only, so a same-cycle response never frees a slot.
    assign bus_req_o = sel_req & ~fifo_full & rst_ni;
    assign handshake = bus_req_o & bus_gnt_i;

    assign bus_addr_o  = (sel == ARB_INSTR) ? instr_addr_i : data_addr_i;
    assign bus_we_o    = (sel == ARB_INSTR) ? 1'b0         : data_we_i;
    assign bus_be_o    = (sel == ARB_INSTR) ? 4'b1111      : data_be_i;
    assign bus_wdata_o = (sel == ARB_INSTR) ? 32'h0        : data_wdata_i;

    assign instr_gnt_o = handshake & (sel == ARB_INSTR);
    assign data_gnt_o  = handshake & (sel == ARB_DATA);

    assign pop            = bus_rvalid_i & ~fifo_empty & rst_ni;
    assign instr_rvalid_o = pop & (head == ARB_INSTR);
    assign data_rvalid_o  = pop & (head == ARB_DATA);
    assign instr_rdata_o  = bus_rdata_i;
    assign data_rdata_o   = bus_rdata_i;
    assign instr_err_o    = bus_err_i;
    assign data_err_o     = bus_err_i;

    always_comb begin
        state_d      = state_q;
        lock_owner_d = lock_owner_q;
        last_owner_d = last_owner_q;
        if (bus_req_o && !bus_gnt_i) begin
            state_d      = ARB_LOCKED;
            lock_owner_d = sel;
        end else if (handshake) begin
            state_d      = ARB_IDLE;
            last_owner_d = sel;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ARB_IDLE;
            lock_owner_q <= ARB_INSTR;
            last_owner_q <= ARB_DATA;
            stale_ok_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            lock_owner_q <= lock_owner_d;
            last_owner_q <= last_owner_d;
            if (handshake) stale_ok_q <= 1'b0;
        end
    end

    ibex_arb_owner_fifo #(
        .Depth (MaxOutstanding)
    ) u_owner_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push       (handshake),
        .push_owner (sel),
        .pop        (pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (head),
        .count      (fifo_count)
    );

    a_known_sel: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !$isunknown({state_q, lock_owner_q, last_owner_q, sel}));
    a_addr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == ARB_LOCKED) |-> $stable(bus_addr_o));
    a_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == ARB_LOCKED) |-> sel_req);
    a_no_rvalid_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus_rvalid_i |-> (!fifo_empty || stale_ok_q));
    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        fifo_count <= CntW'(MaxOutstanding));

endmodule

// File: tb/tb_ibex_bus_arbiter.sv
// Scoreboard bench for ibex_bus_arbiter: expected owners queued at grant, checked at response.
module tb_ibex_bus_arbiter;
    import ibex_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_ni;
    logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_addr_i, instr_rdata_o;
    logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o, data_err_o;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
    logic        bus_req_o, bus_we_o, bus_gnt_i, bus_rvalid_i, bus_err_i;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;

    int checks   = 0;
    int failures = 0;
    arb_owner_e exp_q[$];

    ibex_bus_arbiter #(.MaxOutstanding(2)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_err_o    (instr_err_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_err_o     (data_err_o),
        .data_rdata_o   (data_rdata_o),
        .bus_req_o      (bus_req_o),
        .bus_we_o       (bus_we_o),
        .bus_be_o       (bus_be_o),
        .bus_addr_o     (bus_addr_o),
        .bus_wdata_o    (bus_wdata_o),
        .bus_gnt_i      (bus_gnt_i),
        .bus_rvalid_i   (bus_rvalid_i),
        .bus_err_i      (bus_err_i),
        .bus_rdata_i    (bus_rdata_i)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Request side: expected bus_req_o, owner and address; queues the owner on a handshake.
    task automatic chk_grant(input string tag, input logic exp_req, input arb_owner_e o,
                             input logic [31:0] addr);
        logic g;
        g = exp_req & bus_gnt_i;
        check_eq({tag, "_req"}, bus_req_o, exp_req);
        check_eq({tag, "_ignt"}, instr_gnt_o, g & (o == ARB_INSTR));
        check_eq({tag, "_dgnt"}, data_gnt_o, g & (o == ARB_DATA));
        if (exp_req) begin
            check_eq({tag, "_addr"}, bus_addr_o, addr);
            if (o == ARB_INSTR) begin
                check_eq({tag, "_we"}, bus_we_o, 1'b0);
                check_eq({tag, "_be"}, bus_be_o, 4'hF);
                check_eq({tag, "_wd"}, bus_wdata_o, 32'h0);
            end else begin
                check_eq({tag, "_we"}, bus_we_o, data_we_i);
                check_eq({tag, "_be"}, bus_be_o, data_be_i);
                check_eq({tag, "_wd"}, bus_wdata_o, data_wdata_i);
            end
        end
        if (g) exp_q.push_back(o);
    endtask

    // Response side: pops the oldest expected owner when a response is driven.
    task automatic chk_rsp(input string tag);
        arb_owner_e o;
        if (bus_rvalid_i && exp_q.size() > 0) begin
            o = exp_q.pop_front();
            check_eq({tag, "_irv"}, instr_rvalid_o, o == ARB_INSTR);
            check_eq({tag, "_drv"}, data_rvalid_o, o == ARB_DATA);
            if (o == ARB_INSTR) begin
                check_eq({tag, "_ird"}, instr_rdata_o, bus_rdata_i);
                check_eq({tag, "_ierr"}, instr_err_o, bus_err_i);
            end else begin
                check_eq({tag, "_drd"}, data_rdata_o, bus_rdata_i);
                check_eq({tag, "_derr"}, data_err_o, bus_err_i);
            end
        end else begin
            check_eq({tag, "_irv0"}, instr_rvalid_o, 1'b0);
            check_eq({tag, "_drv0"}, data_rvalid_o, 1'b0);
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        instr_req_i = 1'b1; instr_addr_i = 32'h80;
        data_req_i = 1'b1;  data_we_i = 1'b1; data_be_i = 4'hC;
        data_addr_i = 32'h100; data_wdata_i = 32'hA5A5_0001;
        bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_err_i = 1'b0; bus_rdata_i = 32'h0;

        // Reset: everything quiet even with requests and responses present.
        step(); #1;
        check_eq("rst_req", bus_req_o, 1'b0);
        check_eq("rst_ignt", instr_gnt_o, 1'b0);
        check_eq("rst_dgnt", data_gnt_o, 1'b0);
        check_eq("rst_irv", instr_rvalid_o, 1'b0);
        check_eq("rst_drv", data_rvalid_o, 1'b0);

        // Both requesting from reset: instr first, then alternate with one response per cycle.
        step(); rst_ni = 1'b1; bus_rvalid_i = 1'b0; #1;
        chk_rsp("rr0"); chk_grant("rr0", 1'b1, ARB_INSTR, 32'h80);
        for (int i = 1; i <= 6; i++) begin
            step(); bus_rvalid_i = 1'b1; bus_rdata_i = 32'h0101 * i; #1;
            chk_rsp($sformatf("rr%0d", i));
            if (i % 2 == 1) chk_grant($sformatf("rr%0d", i), 1'b1, ARB_DATA, 32'h100);
            else            chk_grant($sformatf("rr%0d", i), 1'b1, ARB_INSTR, 32'h80);
        end
        step(); instr_req_i = 1'b0; data_req_i = 1'b0; bus_rdata_i = 32'h77; #1;
        chk_rsp("rr_drain"); chk_grant("rr_drain", 1'b0, ARB_INSTR, 32'h0);

        // Data request stalled three cycles; instr arrives meanwhile but cannot steal the lock.
        step(); bus_rvalid_i = 1'b0; bus_gnt_i = 1'b0;
        data_req_i = 1'b1; data_addr_i = 32'h200; data_we_i = 1'b1; data_be_i = 4'h3;
        data_wdata_i = 32'hDEAD_BEEF; #1;
        chk_grant("lk0", 1'b1, ARB_DATA, 32'h200);
        step(); instr_req_i = 1'b1; instr_addr_i = 32'h300; #1;
        chk_grant("lk1", 1'b1, ARB_DATA, 32'h200);
        step(); #1; chk_grant("lk2", 1'b1, ARB_DATA, 32'h200);
        step(); bus_gnt_i = 1'b1; #1; chk_grant("lk3", 1'b1, ARB_DATA, 32'h200);
        // Error response for the data owner.
        step(); instr_req_i = 1'b0; data_req_i = 1'b0; bus_gnt_i = 1'b0;
        bus_rvalid_i = 1'b1; bus_err_i = 1'b1; bus_rdata_i = 32'hBAD; #1;
        chk_rsp("err"); chk_grant("err", 1'b0, ARB_INSTR, 32'h0);

        // Outstanding limit: two grants, then blocked until a response has been absorbed.
        step(); bus_rvalid_i = 1'b0; bus_err_i = 1'b0; bus_gnt_i = 1'b1;
        instr_req_i = 1'b1; instr_addr_i = 32'h400; #1;
        chk_grant("full0", 1'b1, ARB_INSTR, 32'h400);
        step(); #1; chk_grant("full1", 1'b1, ARB_INSTR, 32'h400);
        step(); #1; chk_grant("full2", 1'b0, ARB_INSTR, 32'h400);
        step(); bus_rvalid_i = 1'b1; bus_rdata_i = 32'h33; #1;
        chk_rsp("full3"); chk_grant("full3", 1'b0, ARB_INSTR, 32'h400);
        step(); bus_rvalid_i = 1'b0; #1; chk_grant("full4", 1'b1, ARB_INSTR, 32'h400);
        step(); instr_req_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h44; #1;
        chk_rsp("fd0");
        step(); bus_rdata_i = 32'h55; #1; chk_rsp("fd1");

        // Instr then data, responses route in grant order.
        step(); bus_rvalid_i = 1'b0; instr_req_i = 1'b1; instr_addr_i = 32'h500; #1;
        chk_grant("ord0", 1'b1, ARB_INSTR, 32'h500);
        step(); instr_req_i = 1'b0; data_req_i = 1'b1; data_addr_i = 32'h600; data_we_i = 1'b0; #1;
        chk_grant("ord1", 1'b1, ARB_DATA, 32'h600);
        step(); data_req_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h1111_1111; #1;
        chk_rsp("ord2");
        check_eq("ord2_dpass", data_rdata_o, 32'h1111_1111);
        step(); bus_rdata_i = 32'h2222_2222; #1; chk_rsp("ord3");

        // Reset while locked with one outstanding: the late response is dropped.
        step(); bus_rvalid_i = 1'b0; instr_req_i = 1'b1; instr_addr_i = 32'h700; #1;
        chk_grant("rl0", 1'b1, ARB_INSTR, 32'h700);
        step(); instr_req_i = 1'b0; data_req_i = 1'b1; data_addr_i = 32'h800; bus_gnt_i = 1'b0; #1;
        chk_grant("rl1", 1'b1, ARB_DATA, 32'h800);
        step(); #1; chk_grant("rl2", 1'b1, ARB_DATA, 32'h800);
        #1; rst_ni = 1'b0; #1;
        check_eq("rl_rst_req", bus_req_o, 1'b0);
        check_eq("rl_rst_dgnt", data_gnt_o, 1'b0);
        exp_q.delete();
        step(); data_req_i = 1'b0;
        step(); rst_ni = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h99; #1;
        chk_rsp("rl_late");
        // Empty FIFO after reset: two grants fit, instr wins the first tie.
        step(); bus_rvalid_i = 1'b0; bus_gnt_i = 1'b1;
        instr_req_i = 1'b1; data_req_i = 1'b1; instr_addr_i = 32'h900; data_addr_i = 32'hA00; #1;
        chk_rsp("post0"); chk_grant("post0", 1'b1, ARB_INSTR, 32'h900);
        step(); #1; chk_grant("post1", 1'b1, ARB_DATA, 32'hA00);
        step(); #1; chk_grant("post2", 1'b0, ARB_INSTR, 32'h900);
        step(); instr_req_i = 1'b0; data_req_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hC1; #1;
        chk_rsp("post3");
        step(); bus_rdata_i = 32'hC2; #1; chk_rsp("post4");
        step(); bus_rvalid_i = 1'b0;

        check_eq("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
